// File: rtl/fm_accum_relu_guard.sv
// fm_accum_relu_guard: multi-channel psum accumulator with bias, ReLU,
// rounding shift, 8/4-bit saturation and a per-lane non-zero guard mask.
module fm_accum_relu_guard #(
    parameter int LANES      = 6,
    parameter int PSUM_WIDTH = 32,
    parameter int BIAS_WIDTH = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int DEPTH      = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [7:0]                    w_num,
    input  logic [7:0]                    h_num,
    input  logic [7:0]                    c_num,
    input  logic                          bit_mode,
    input  logic [3:0]                    shift,
    input  logic [LANES*BIAS_WIDTH-1:0]   bias_i,
    output logic                          cfg_err,
    input  logic                          psum_valid,
    output logic                          psum_ready,
    input  logic [LANES*PSUM_WIDTH-1:0]   psum_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*OUT_WIDTH-1:0]    out_data,
    output logic [LANES-1:0]              guard_o,
    output logic                          done
);

    localparam int PW = PSUM_WIDTH;
    localparam int BW = BIAS_WIDTH;
    localparam int OW = OUT_WIDTH;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW:0] LIM_WIDE = (PW+1)'((2 ** OW) - 1);
    localparam logic [PW:0] LIM_NIB  = (PW+1)'(15);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                  r_state;
    logic [15:0]             r_npos;
    logic [7:0]              r_c;
    logic                    r_mode;
    logic [3:0]              r_shift;
    logic [LANES*BW-1:0]     r_bias;
    logic [15:0]             r_pos;
    logic [7:0]              r_ch;
    logic                    r_out_valid;
    logic [LANES*OW-1:0]     r_out_data;
    logic [LANES-1:0]        r_guard;
    logic                    r_cfg_err;
    logic                    r_done;

    logic [LANES*PW-1:0]     r_buf [DEPTH];

    logic [15:0]             w_cfg_prod;
    logic                    w_cfg_legal;
    logic                    w_last_ch;
    logic                    w_last_pos;
    logic                    w_psum_ready;
    logic                    w_acc;
    logic                    w_drain;
    logic [LANES*PW-1:0]     w_rd;
    logic [LANES*PW-1:0]     w_sum_all;
    logic [LANES*OW-1:0]     w_out_all;
    logic [LANES-1:0]        w_guard_all;

    assign w_cfg_prod  = {8'd0, w_num} * {8'd0, h_num};
    assign w_cfg_legal = (w_num != 8'd0) && (h_num != 8'd0) &&
                         (c_num != 8'd0) &&
                         ({16'd0, w_cfg_prod} <= 32'(DEPTH));

    assign w_last_ch    = (r_ch == r_c - 8'd1);
    assign w_last_pos   = (r_pos == r_npos - 16'd1);
    // Only the last channel can be blocked, and only by a full, stuck output.
    assign w_psum_ready = (r_state == S_ACCUM) &&
                          (!w_last_ch || !r_out_valid || out_ready);
    assign w_acc        = psum_valid && w_psum_ready;
    assign w_drain      = r_out_valid && out_ready;
    assign w_rd         = r_buf[r_pos[AW-1:0]];

    // Per-lane datapath: accumulate, saturate, ReLU, round-shift, clamp.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [PW-1:0] w_bias_x;
        logic        [PW-1:0] w_base;
        logic        [PW-1:0] w_ps;
        logic        [PW:0]   w_ext;
        logic        [PW-1:0] w_sat;
        logic        [PW-1:0] w_relu;
        logic        [PW:0]   w_rnd;
        logic        [PW:0]   w_add;
        logic        [PW:0]   w_q;
        logic        [PW:0]   w_lim;
        logic        [OW-1:0] w_lane;

        assign w_bias_x = {{(PW-BW){r_bias[l*BW+BW-1]}},
                           r_bias[l*BW +: BW]};
        assign w_base   = (r_ch == 8'd0) ? w_bias_x : w_rd[l*PW +: PW];
        assign w_ps     = psum_i[l*PW +: PW];
        assign w_ext    = {w_base[PW-1], w_base} + {w_ps[PW-1], w_ps};
        assign w_sat    = (w_ext[PW] == w_ext[PW-1]) ? w_ext[PW-1:0] :
                          (w_ext[PW] ? {1'b1, {(PW-1){1'b0}}}
                                     : {1'b0, {(PW-1){1'b1}}});
        assign w_relu   = w_sat[PW-1] ? '0 : w_sat;
        assign w_rnd    = (r_shift == 4'd0) ? '0 :
                          ({{PW{1'b0}}, 1'b1} << (r_shift - 4'd1));
        assign w_add    = {1'b0, w_relu} + w_rnd;
        assign w_q      = w_add >> r_shift;
        assign w_lim    = r_mode ? LIM_NIB : LIM_WIDE;
        assign w_lane   = (w_q > w_lim) ? w_lim[OW-1:0] : w_q[OW-1:0];

        assign w_sum_all[l*PW +: PW]   = w_sat;
        assign w_out_all[l*OW +: OW]   = w_lane;
        assign w_guard_all[l]          = (w_lane != '0);
    end

    // Psum buffer write; contents survive reset since channel 0 overwrites.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_buf[r_pos[AW-1:0]] <= w_sum_all;
        end
    end

    // Layer FSM, beat counters and registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_npos      <= '0;
            r_c         <= '0;
            r_mode      <= 1'b0;
            r_shift     <= '0;
            r_bias      <= '0;
            r_pos       <= '0;
            r_ch        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_guard     <= '0;
            r_cfg_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            r_done    <= 1'b0;
            if (w_drain) begin
                r_out_valid <= 1'b0;
            end
            if (w_acc && w_last_ch) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_out_all;
                r_guard     <= w_guard_all;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (w_cfg_legal) begin
                            r_npos  <= w_cfg_prod;
                            r_c     <= c_num;
                            r_mode  <= bit_mode;
                            r_shift <= shift;
                            r_bias  <= bias_i;
                            r_pos   <= '0;
                            r_ch    <= '0;
                            r_state <= S_ACCUM;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_acc) begin
                        if (w_last_pos) begin
                            r_pos <= '0;
                            if (w_last_ch) begin
                                r_ch    <= '0;
                                r_state <= S_FLUSH;
                            end else begin
                                r_ch <= r_ch + 8'd1;
                            end
                        end else begin
                            r_pos <= r_pos + 16'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_drain) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready  = (r_state == S_IDLE);
    assign cfg_err    = r_cfg_err;
    assign psum_ready = w_psum_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign guard_o    = r_guard;
    assign done       = r_done;

endmodule
